add_round: RTL and testbench
============================

// Module: add_round
// PURPOSE
//   AES AddRoundKey datapath stage, byte-serial: XORs one state byte with the
//   matching round-subkey byte each enabled cycle and registers the result.
//   Sits between the key-schedule byte stream and the next cipher stage
//   (SubBytes/ShiftRows). Also tracks byte position within a 16-byte AES block.
// PARAMETERS
//   DATA_WIDTH   8    width of state/subkey/result byte
//   BLOCK_BYTES  16   bytes per AES state block (byte counter modulus)
// PORTS
//   clk            in   1           rising-edge system clock
//   n_rst          in   1           asynchronous active-low reset
//   around_enable  in   1           process olddata/subkey this cycle
//   subkey         in   DATA_WIDTH  round-key byte
//   olddata        in   DATA_WIDTH  incoming state byte
//   newdata        out  DATA_WIDTH  registered olddata ^ subkey
//   newdata_valid  out  1           newdata updated on the last clock edge
//   byte_idx       out  4           index (0..BLOCK_BYTES-1) of next byte to process
//   block_done     out  1           pulses with the last byte of a block
// BEHAVIOUR
//   Reset (n_rst=0, async, no clock needed): newdata=0, newdata_valid=0,
//     byte_idx=0, block_done=0. Reset asserted mid-block discards the partial
//     block. Outputs stay at reset values while n_rst=0, even with
//     around_enable=1.
//   Rising clk edge, around_enable=1:
//     newdata <= olddata ^ subkey; newdata_valid <= 1.
//     block_done <= (byte_idx == BLOCK_BYTES-1).
//     byte_idx <= (byte_idx == BLOCK_BYTES-1) ? 0 : byte_idx+1  (wraps).
//   Rising clk edge, around_enable=0: newdata holds its last value;
//     newdata_valid <= 0; block_done <= 0; byte_idx holds.
//   Latency: exactly 1 clock from inputs sampled to newdata. No combinational
//     path from inputs to outputs. Inputs are sampled only at the clock edge.
//   Width rule: bitwise XOR, no carry. Output width = DATA_WIDTH.
//   Back-to-back enables process one byte per cycle with no bubbles.
//   No handshake/backpressure. The upstream stage drives around_enable as valid.
//   block_done and newdata_valid are single-cycle strobes unless enable stays
//     high. Consecutive blocks are processed without a gap.
// TESTING
//   1. n_rst=0, around_enable=1, subkey=8'hCC, olddata=8'hAA -> newdata=8'h00,
//      valid=0, byte_idx=0 regardless of clocks.
//   2. Release reset, enable=1, subkey=8'hCC, olddata=8'hAA, one clk ->
//      newdata=8'h66, valid=1, byte_idx=1.
//   3. Then enable=0, subkey=8'h0F, olddata=8'hC3, several clks -> newdata
//      holds 8'h66, valid=0, byte_idx holds 1.
//   4. Then enable=1 with the same inputs, one clk -> newdata=8'hCC, valid=1.
//   5. From reset, 16 enabled clks with random bytes -> each newdata equals its
//      XOR; block_done=1 only on the 16th byte; byte_idx wraps to 0.
//   6. Assert n_rst asynchronously between edges mid-block (byte_idx=7) ->
//      all outputs clear immediately; next enabled byte restarts at idx 0.

Source files
------------

// File: rtl/add_round.sv
// add_round: byte-serial AES AddRoundKey stage.
//   Each enabled cycle XORs one state byte with the matching round-key byte
//   and registers the result. It also tracks where that byte sits inside a
//   BLOCK_BYTES-byte AES state block.
// Ports:
//   clk            rising-edge clock
//   n_rst          async active-low reset
//   around_enable  process olddata/subkey on this edge
//   subkey         round-key byte
//   olddata        incoming state byte
//   newdata        registered olddata ^ subkey (holds while idle)
//   newdata_valid  high for one cycle after each processed byte
//   byte_idx       index of the next byte to process (0..BLOCK_BYTES-1)
//   block_done     high with the result of the last byte of a block
module add_round #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  around_enable,
  input  logic [DATA_WIDTH-1:0] subkey,
  input  logic [DATA_WIDTH-1:0] olddata,
  output logic [DATA_WIDTH-1:0] newdata,
  output logic                  newdata_valid,
  output logic [3:0]            byte_idx,
  output logic                  block_done
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

  logic [DATA_WIDTH-1:0] newdata_q, newdata_d;
  logic                  valid_q, valid_d;
  logic [3:0]            idx_q, idx_d;
  logic                  done_q, done_d;

  // Strobes default low, so they only survive one cycle unless the
  // enable stays high. Data and index hold while idle.
  always_comb begin
    newdata_d = newdata_q;
    valid_d   = 1'b0;
    idx_d     = idx_q;
    done_d    = 1'b0;
    if (around_enable) begin
      newdata_d = olddata ^ subkey;
      valid_d   = 1'b1;
      done_d    = (idx_q == LAST_IDX);
      idx_d     = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      newdata_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      newdata_q <= newdata_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign newdata       = newdata_q;
  assign newdata_valid = valid_q;
  assign byte_idx      = idx_q;
  assign block_done    = done_q;

endmodule

// File: tb/tb_add_round.sv
module tb_add_round;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       around_enable;
  logic [7:0] subkey;
  logic [7:0] olddata;
  logic [7:0] newdata;
  logic       newdata_valid;
  logic [3:0] byte_idx;
  logic       block_done;

  int checks = 0;
  int errors = 0;

  add_round #(.DATA_WIDTH(8), .BLOCK_BYTES(16)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .around_enable (around_enable),
    .subkey        (subkey),
    .olddata       (olddata),
    .newdata       (newdata),
    .newdata_valid (newdata_valid),
    .byte_idx      (byte_idx),
    .block_done    (block_done)
  );

  always #5 clk = ~clk;

  // Stimulus tables for one full block.
  logic [7:0] od_tab [16] = '{8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                              8'hDE, 8'hF0, 8'h0F, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h81};
  logic [7:0] sk_tab [16] = '{8'h00, 8'h00, 8'hFF, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB,
                              8'hED, 8'h0F, 8'hF0, 8'h5A, 8'h5A, 8'hC3, 8'h3C, 8'h18};

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; around_enable = 1'b1; subkey = 8'hCC; olddata = 8'hAA;
    #1;
    checks++;
    if (newdata !== 8'h00 || newdata_valid !== 1'b0 || byte_idx !== 4'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_nocl: got nd=%h v=%b idx=%0d bd=%b want 00 0 0 0", newdata, newdata_valid, byte_idx, block_done);
    end
    repeat (3) tick();
    checks++;
    if (newdata !== 8'h00 || newdata_valid !== 1'b0 || byte_idx !== 4'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_clk: got nd=%h v=%b idx=%0d bd=%b want 00 0 0 0", newdata, newdata_valid, byte_idx, block_done);
    end
  endtask

  task automatic test_xor_basic();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++;
    if (newdata !== 8'h66 || newdata_valid !== 1'b1 || byte_idx !== 4'd1 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL xor_basic: got nd=%h v=%b idx=%0d bd=%b want 66 1 1 0", newdata, newdata_valid, byte_idx, block_done);
    end
  endtask

  task automatic test_hold();
    around_enable = 1'b0; subkey = 8'h0F; olddata = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (newdata !== 8'h66 || newdata_valid !== 1'b0 || byte_idx !== 4'd1 || block_done !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got nd=%h v=%b idx=%0d bd=%b want 66 0 1 0", i, newdata, newdata_valid, byte_idx, block_done);
      end
    end
  endtask

  task automatic test_reenable();
    around_enable = 1'b1;
    tick();
    checks++;
    if (newdata !== 8'hCC || newdata_valid !== 1'b1 || byte_idx !== 4'd2) begin
      errors++;
      $display("FAIL reenable: got nd=%h v=%b idx=%0d want CC 1 2", newdata, newdata_valid, byte_idx);
    end
    around_enable = 1'b0;
  endtask

  task automatic test_block();
    logic [7:0] exp;
    // Fresh block from reset.
    n_rst = 1'b0; #1; @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      around_enable = 1'b1; olddata = od_tab[i]; subkey = sk_tab[i];
      exp = od_tab[i] ^ sk_tab[i];
      tick();
      checks++;
      if (newdata !== exp || newdata_valid !== 1'b1 || block_done !== (i == 15) ||
          byte_idx !== 4'((i + 1) % 16)) begin
        errors++;
        $display("FAIL block_b%0d: got nd=%h v=%b bd=%b idx=%0d want %h 1 %b %0d",
                 i, newdata, newdata_valid, block_done, byte_idx, exp, (i == 15), (i + 1) % 16);
      end
    end
    around_enable = 1'b0;
    tick();
    checks++;
    if (block_done !== 1'b0 || newdata_valid !== 1'b0 || byte_idx !== 4'd0 || newdata !== 8'h99) begin
      errors++;
      $display("FAIL block_idle: got bd=%b v=%b idx=%0d nd=%h want 0 0 0 99", block_done, newdata_valid, byte_idx, newdata);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int bad = 0;
    // 32 bytes with no gap: two blocks, block_done exactly on bytes 15 and 31.
    for (int i = 0; i < 32; i++) begin
      around_enable = 1'b1; olddata = 8'(i * 7); subkey = 8'hA5;
      tick();
      if (block_done) done_cnt++;
      if (newdata !== (8'(i * 7) ^ 8'hA5) || newdata_valid !== 1'b1 ||
          block_done !== ((i % 16) == 15) || byte_idx !== 4'((i + 1) % 16)) bad++;
    end
    around_enable = 1'b0;
    checks++;
    if (bad != 0 || done_cnt != 2) begin
      errors++;
      $display("FAIL back_to_back: got bad=%0d done_cnt=%0d want 0 2", bad, done_cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      around_enable = 1'b1; olddata = 8'h10 + 8'(i); subkey = 8'h01;
      tick();
    end
    checks++;
    if (byte_idx !== 4'd7) begin
      errors++;
      $display("FAIL async_pre: got idx=%0d want 7", byte_idx);
    end
    #2;  // between edges
    n_rst = 1'b0;
    #1;
    checks++;
    if (newdata !== 8'h00 || newdata_valid !== 1'b0 || byte_idx !== 4'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got nd=%h v=%b idx=%0d bd=%b want 00 0 0 0", newdata, newdata_valid, byte_idx, block_done);
    end
    tick();  // enable still high while in reset
    checks++;
    if (newdata !== 8'h00 || newdata_valid !== 1'b0 || byte_idx !== 4'd0) begin
      errors++;
      $display("FAIL async_hold: got nd=%h v=%b idx=%0d want 00 0 0", newdata, newdata_valid, byte_idx);
    end
    @(negedge clk);
    n_rst = 1'b1; olddata = 8'h3C; subkey = 8'hFF;
    tick();
    checks++;
    if (newdata !== 8'hC3 || newdata_valid !== 1'b1 || byte_idx !== 4'd1 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL async_restart: got nd=%h v=%b idx=%0d bd=%b want C3 1 1 0", newdata, newdata_valid, byte_idx, block_done);
    end
    around_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_xor_basic();
    test_hold();
    test_reenable();
    test_block();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
